// File: rtl/fb_pkg.sv
// Shared types and helpers for the frame-buffer read burst generator.
package fb_pkg;

  localparam int AXI_LEN_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DRAIN = 2'd2
  } fb_state_t;

  // Bytes carried by one AXI read beat.
  function automatic int fb_bytes(input int data_w);
    return data_w / 8;
  endfunction

  // Width of the beat index inside one line-buffer slot.
  function automatic int fb_beat_w(input int x_wid, input int data_w);
    return x_wid - $clog2(data_w / 8);
  endfunction

endpackage

// File: rtl/fb_outst_cnt.sv
// Up/down counter of outstanding AR bursts, saturating at MAX.
module fb_outst_cnt #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [CW-1:0] o_cnt,
  output logic          o_full,
  output logic          o_zero
);

  logic [CW-1:0] r_cnt;

  // Simultaneous increment and decrement cancel out.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_cnt <= '0;
    end else if (i_inc && !i_dec && (r_cnt != CW'(MAX))) begin
      r_cnt <= r_cnt + 1'b1;
    end else if (i_dec && !i_inc && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_cnt  = r_cnt;
  assign o_full = (r_cnt == CW'(MAX));
  assign o_zero = (r_cnt == '0);

endmodule

// File: rtl/fb_rd_burst_gen.sv
// Fetches one frame-buffer line window per request as AXI read bursts and
// writes the returned beats into a multi-slot line buffer.
module fb_rd_burst_gen
  import fb_pkg::*;
#(
  parameter int DATA_W    = 512,
  parameter int BURST_LEN = 16,
  parameter int MAX_OUTST = 4,
  parameter int X_WID     = 12,
  parameter int Y_WID     = 12,
  parameter int LB_SLOT_W = 2,
  parameter int FRAME_SH  = 24
) (
  input  logic                                              axi_clk,
  input  logic                                              i_arst,
  input  logic                                              i_frame_start,
  input  logic                                              i_line_req,
  input  logic [2:0]                                        i_frame_idx,
  input  logic [31:0]                                       i_base_addr,
  input  logic [X_WID-1:0]                                  i_x_start,
  input  logic [X_WID-1:0]                                  i_x_win,
  input  logic [Y_WID-1:0]                                  i_y_start,
  input  logic [Y_WID-1:0]                                  i_y_win,
  output logic                                              o_ar_valid,
  output logic [31:0]                                       o_ar_addr,
  output logic [AXI_LEN_W-1:0]                              o_ar_len,
  input  logic                                              i_ar_ready,
  input  logic                                              i_r_valid,
  input  logic [DATA_W-1:0]                                 i_r_data,
  input  logic                                              i_r_last,
  output logic                                              o_r_ready,
  output logic                                              o_lb_we,
  output logic [LB_SLOT_W+fb_beat_w(X_WID, DATA_W)-1:0]     o_lb_waddr,
  output logic [DATA_W-1:0]                                 o_lb_wdata,
  output logic                                              o_busy,
  output logic                                              o_line_done,
  output logic                                              o_ovf
);

  localparam int BYTES   = fb_bytes(DATA_W);
  localparam int LOG2B   = $clog2(BYTES);
  localparam int BEAT_W  = fb_beat_w(X_WID, DATA_W);
  localparam int CNT_RAW = X_WID + 2 - LOG2B;
  localparam int CNT_W   = (CNT_RAW > 9) ? CNT_RAW : 9;
  localparam int OW      = $clog2(MAX_OUTST + 1);

  fb_state_t         r_state, w_state_nx;
  logic              r_pend, r_ovf, r_fs_pend;
  logic [Y_WID-1:0]  r_ycnt, r_line_y;
  logic [31:0]       r_line_addr;
  logic [CNT_W-1:0]  r_beats, r_iss, r_rx;

  logic [X_WID-1:0]  w_x0;
  logic [X_WID+1:0]  w_span;
  logic [CNT_W-1:0]  w_beats, w_left, w_len;
  logic [31:0]       w_line_addr;
  logic [Y_WID:0]    w_y_inc;
  logic [Y_WID-1:0]  w_y_next;
  logic              w_start, w_done, w_ar_hs, w_r_hs, w_full, w_zero, w_last_burst;
  logic [OW-1:0]     w_outst;

  // Line geometry from the live configuration, latched at line start.
  assign w_x0        = i_x_start & ~X_WID'(BYTES - 1);
  assign w_span      = (X_WID+2)'(i_x_start - w_x0) + (X_WID+2)'(i_x_win) + (X_WID+2)'(BYTES - 1);
  assign w_beats     = (i_x_win == '0) ? '0 : CNT_W'(w_span >> LOG2B);
  assign w_line_addr = i_base_addr + (32'(i_frame_idx) << FRAME_SH)
                     + ((32'(i_y_start) + 32'(r_ycnt)) << X_WID) + 32'(w_x0);

  assign w_left       = r_beats - r_iss;
  assign w_len        = (w_left > CNT_W'(BURST_LEN)) ? CNT_W'(BURST_LEN) : w_left;
  assign w_last_burst = ((r_iss + w_len) == r_beats);
  assign w_start      = (r_state == ST_IDLE) && r_pend;
  assign w_ar_hs      = o_ar_valid && i_ar_ready;
  assign w_r_hs       = i_r_valid && o_r_ready;

  assign w_y_inc  = (Y_WID+1)'(r_line_y) + (Y_WID+1)'(1);
  assign w_y_next = (w_y_inc >= {1'b0, i_y_win}) ? '0 : w_y_inc[Y_WID-1:0];

  fb_outst_cnt #(.MAX(MAX_OUTST), .CW(OW)) u_outst (
    .i_clk  (axi_clk),
    .i_rst  (i_arst),
    .i_inc  (w_ar_hs),
    .i_dec  (w_r_hs && i_r_last),
    .o_cnt  (w_outst),
    .o_full (w_full),
    .o_zero (w_zero)
  );

  // State register.
  always_ff @(posedge axi_clk or posedge i_arst) begin
    if (i_arst) r_state <= ST_IDLE;
    else        r_state <= w_state_nx;
  end

  // Next-state, AR valid and line-done decode.
  always_comb begin
    w_state_nx = r_state;
    o_ar_valid = 1'b0;
    w_done     = 1'b0;
    unique case (r_state)
      ST_IDLE:  if (r_pend) w_state_nx = (w_beats == '0) ? ST_DRAIN : ST_ADDR;
      ST_ADDR: begin
        o_ar_valid = !w_full;
        if (!w_full && i_ar_ready && w_last_burst) w_state_nx = ST_DRAIN;
      end
      ST_DRAIN: if (r_rx == r_beats) begin
        w_done     = 1'b1;
        w_state_nx = ST_IDLE;
      end
      default:  w_state_nx = ST_IDLE;
    endcase
  end

  // Per-line datapath: latch geometry at start, count issued and received beats.
  always_ff @(posedge axi_clk or posedge i_arst) begin
    if (i_arst) begin
      r_line_addr <= '0;
      r_line_y    <= '0;
      r_beats     <= '0;
      r_iss       <= '0;
      r_rx        <= '0;
    end else if (w_start) begin
      r_line_addr <= w_line_addr;
      r_line_y    <= r_ycnt;
      r_beats     <= w_beats;
      r_iss       <= '0;
      r_rx        <= '0;
    end else begin
      if (w_ar_hs) r_iss <= r_iss + w_len;
      if (w_r_hs)  r_rx  <= r_rx + 1'b1;
    end
  end

  // One-deep request queue with sticky overflow; a request arriving as the
  // pending one is consumed refills the queue instead of being dropped.
  always_ff @(posedge axi_clk or posedge i_arst) begin
    if (i_arst) begin
      r_pend <= 1'b0;
      r_ovf  <= 1'b0;
    end else if (i_line_req) begin
      if (r_pend && !w_start) r_ovf  <= 1'b1;
      else                    r_pend <= 1'b1;
    end else if (w_start) begin
      r_pend <= 1'b0;
    end
  end

  // Line counter: advances on completion; a frame start seen while a line is
  // in flight is remembered so that completion leaves the counter at zero.
  always_ff @(posedge axi_clk or posedge i_arst) begin
    if (i_arst) begin
      r_ycnt    <= '0;
      r_fs_pend <= 1'b0;
    end else if (w_done) begin
      r_ycnt    <= (r_fs_pend || i_frame_start) ? '0 : w_y_next;
      r_fs_pend <= 1'b0;
    end else if (i_frame_start) begin
      r_ycnt    <= '0;
      r_fs_pend <= (r_state != ST_IDLE) || w_start;
    end
  end

  assign o_ar_addr   = r_line_addr + (32'(r_iss) << LOG2B);
  assign o_ar_len    = (w_left == '0) ? '0 : AXI_LEN_W'(w_len - 1'b1);
  assign o_r_ready   = !w_zero || (r_state == ST_ADDR);
  assign o_lb_we     = w_r_hs;
  assign o_lb_waddr  = {r_line_y[LB_SLOT_W-1:0], r_rx[BEAT_W-1:0]};
  assign o_lb_wdata  = i_r_data;
  assign o_busy      = (r_state != ST_IDLE);
  assign o_line_done = w_done;
  assign o_ovf       = r_ovf;

endmodule

// File: tb/tb_fb_rd_burst_gen.sv
// Scoreboard bench for fb_rd_burst_gen with a simple AXI read slave model.
module tb_fb_rd_burst_gen;

  localparam int DATA_W    = 512;
  localparam int BURST_LEN = 16;
  localparam int MAX_OUTST = 2;
  localparam int X_WID     = 12;
  localparam int Y_WID     = 12;
  localparam int LB_SLOT_W = 2;
  localparam int FRAME_SH  = 24;
  localparam int WA_W      = LB_SLOT_W + X_WID - 6;

  logic              axi_clk = 1'b0;
  logic              i_arst = 1'b1;
  logic              i_frame_start = 1'b0, i_line_req = 1'b0;
  logic [2:0]        i_frame_idx = 3'd1;
  logic [31:0]       i_base_addr = 32'h1000_0000;
  logic [X_WID-1:0]  i_x_start = '0, i_x_win = '0;
  logic [Y_WID-1:0]  i_y_start = 12'd5, i_y_win = 12'd3;
  logic              o_ar_valid, i_ar_ready = 1'b0, i_r_valid = 1'b0, i_r_last = 1'b0;
  logic [31:0]       o_ar_addr;
  logic [7:0]        o_ar_len;
  logic [DATA_W-1:0] i_r_data = '0;
  logic              o_r_ready, o_lb_we, o_busy, o_line_done, o_ovf;
  logic [WA_W-1:0]   o_lb_waddr;
  logic [DATA_W-1:0] o_lb_wdata;

  fb_rd_burst_gen #(
    .DATA_W(DATA_W), .BURST_LEN(BURST_LEN), .MAX_OUTST(MAX_OUTST),
    .X_WID(X_WID), .Y_WID(Y_WID), .LB_SLOT_W(LB_SLOT_W), .FRAME_SH(FRAME_SH)
  ) dut (
    .axi_clk(axi_clk), .i_arst(i_arst), .i_frame_start(i_frame_start),
    .i_line_req(i_line_req), .i_frame_idx(i_frame_idx), .i_base_addr(i_base_addr),
    .i_x_start(i_x_start), .i_x_win(i_x_win), .i_y_start(i_y_start), .i_y_win(i_y_win),
    .o_ar_valid(o_ar_valid), .o_ar_addr(o_ar_addr), .o_ar_len(o_ar_len),
    .i_ar_ready(i_ar_ready), .i_r_valid(i_r_valid), .i_r_data(i_r_data),
    .i_r_last(i_r_last), .o_r_ready(o_r_ready), .o_lb_we(o_lb_we),
    .o_lb_waddr(o_lb_waddr), .o_lb_wdata(o_lb_wdata), .o_busy(o_busy),
    .o_line_done(o_line_done), .o_ovf(o_ovf)
  );

  always #5 axi_clk = ~axi_clk;

  int unsigned checks = 0, failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_w(input string name, input logic [DATA_W-1:0] act, input logic [DATA_W-1:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Expected transactions, pushed by the stimulus.
  logic [31:0]     exp_ar_addr[$];
  logic [7:0]      exp_ar_len[$];
  logic [WA_W-1:0] exp_wa[$];
  logic [31:0]     exp_wd[$];

  task automatic exp_line(input logic [31:0] la, input int unsigned nb, input int unsigned slot);
    int unsigned iss = 0;
    int unsigned n;
    while (iss < nb) begin
      n = ((nb - iss) > BURST_LEN) ? BURST_LEN : (nb - iss);
      exp_ar_addr.push_back(la + 32'(iss * 64));
      exp_ar_len.push_back(8'(n - 1));
      iss += n;
    end
    for (int unsigned k = 0; k < nb; k++) begin
      exp_wa.push_back(WA_W'((slot << 6) | k));
      exp_wd.push_back(la + 32'(k * 64));
    end
  endtask

  // Monitor: pops and compares whenever the DUT presents a transaction.
  int unsigned mcyc = 0, done_cnt = 0, ar_cnt = 0, lb_cnt = 0;
  int unsigned ar_cyc[$], rl_cyc[$], done_cyc[$];
  logic        hold_pend = 1'b0;
  logic [31:0] hold_addr = '0;
  logic [7:0]  hold_len = '0;

  always @(negedge axi_clk) begin
    mcyc++;
    if (i_arst) begin
      hold_pend = 1'b0;
    end else begin
      if (hold_pend && o_ar_valid) begin
        check("ar_hold_addr", 64'(o_ar_addr), 64'(hold_addr));
        check("ar_hold_len", 64'(o_ar_len), 64'(hold_len));
      end
      hold_pend = o_ar_valid && !i_ar_ready;
      hold_addr = o_ar_addr;
      hold_len  = o_ar_len;
      if (o_ar_valid && i_ar_ready) begin
        ar_cnt++;
        ar_cyc.push_back(mcyc);
        if (exp_ar_addr.size() == 0) begin
          checks++; failures++;
          $display("FAIL ar_unexpected actual=%0h required=none", o_ar_addr);
        end else begin
          check("ar_addr", 64'(o_ar_addr), 64'(exp_ar_addr.pop_front()));
          check("ar_len", 64'(o_ar_len), 64'(exp_ar_len.pop_front()));
        end
      end
      if (o_lb_we) begin
        lb_cnt++;
        if (exp_wa.size() == 0) begin
          checks++; failures++;
          $display("FAIL lb_unexpected actual=%0h required=none", o_lb_waddr);
        end else begin
          check("lb_waddr", 64'(o_lb_waddr), 64'(exp_wa.pop_front()));
          check_w("lb_wdata", o_lb_wdata, {16{exp_wd.pop_front()}});
        end
      end
      if (i_r_valid && o_r_ready && i_r_last) rl_cyc.push_back(mcyc);
      if (o_line_done) begin
        done_cnt++;
        done_cyc.push_back(mcyc);
      end
    end
  end

  // AXI read slave: accepts ARs, returns address-tagged beats after r_delay.
  int unsigned r_delay = 2;
  bit          ar_hold = 1'b0;
  logic [31:0] rq_addr[$];
  int unsigned rq_len[$], rq_due[$];
  int unsigned rb = 0, rcyc = 0, stale_left = 0;
  bit          stale_on = 1'b0;

  always begin
    @(negedge axi_clk);
    rcyc++;
    if (i_arst) begin
      // Beats owed by the abandoned transfer still show up after reset.
      foreach (rq_len[j]) stale_left += rq_len[j];
      stale_left -= rb;
      rq_addr.delete(); rq_len.delete(); rq_due.delete();
      rb = 0;
    end else begin
      if (i_r_valid && o_r_ready && !stale_on && rq_len.size() > 0) begin
        rb++;
        if (rb == rq_len[0]) begin
          void'(rq_addr.pop_front()); void'(rq_len.pop_front()); void'(rq_due.pop_front());
          rb = 0;
        end
      end
      if (o_ar_valid && i_ar_ready) begin
        rq_addr.push_back(o_ar_addr);
        rq_len.push_back(int'(o_ar_len) + 1);
        rq_due.push_back(rcyc + r_delay);
      end
    end
    @(posedge axi_clk);
    #1;
    i_ar_ready = ar_hold ? 1'b1 : ~i_ar_ready;
    stale_on = 1'b0;
    if (!i_arst && stale_left > 0) begin
      i_r_valid = 1'b1; i_r_last = 1'b1; i_r_data = {16{32'hDEAD_BEEF}};
      stale_left--; stale_on = 1'b1;
    end else if (!i_arst && rq_len.size() > 0 && rcyc >= rq_due[0]) begin
      i_r_valid = 1'b1;
      i_r_last  = (rb == rq_len[0] - 1);
      i_r_data  = {16{rq_addr[0] + 32'(rb * 64)}};
    end else begin
      i_r_valid = 1'b0; i_r_last = 1'b0;
    end
  end

  task automatic step(input int unsigned n = 1);
    repeat (n) @(posedge axi_clk);
    #1;
  endtask

  task automatic pulse_req();
    i_line_req = 1'b1; step(); i_line_req = 1'b0;
  endtask

  task automatic wait_done(input int unsigned target, input int unsigned bound, input string name);
    int unsigned n = 0;
    while (done_cnt < target && n < bound) begin step(); n++; end
    if (done_cnt < target) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, done_cnt, target);
    end
  endtask

  task automatic wait_ar(input int unsigned target, input int unsigned bound, input string name);
    int unsigned n = 0;
    while (ar_cnt < target && n < bound) begin step(); n++; end
    if (ar_cnt < target) begin
      checks++; failures++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, ar_cnt, target);
    end
  endtask

  task automatic wait_busy(input string name);
    int unsigned n = 0;
    while (!o_busy && n < 20) begin step(); n++; end
    check({name, "_busy"}, 64'(o_busy), 64'(1));
  endtask

  task automatic chk_rst(input string name);
    check({name, "_ctrl"}, 64'({o_ar_valid, o_r_ready, o_lb_we, o_busy, o_line_done, o_ovf}), 64'(0));
    check({name, "_ar_addr"}, 64'(o_ar_addr), 64'(0));
    check({name, "_ar_len"}, 64'(o_ar_len), 64'(0));
    check({name, "_lb_waddr"}, 64'(o_lb_waddr), 64'(0));
  endtask

  task automatic chk_drained(input string name);
    check({name, "_ar_left"}, 64'(exp_ar_addr.size()), 64'(0));
    check({name, "_lb_left"}, 64'(exp_wa.size()), 64'(0));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned d0, a0, r0, l0, m;
    step(3);
    chk_rst("rst0");
    i_arst = 1'b0;
    step(3);

    // 1920-byte line, 512-bit beats: 30 beats as 16 + 14.
    d0 = done_cnt;
    i_x_start = 12'd0; i_x_win = 12'd1920;
    exp_line(32'h1100_5000, 30, 0);
    pulse_req();
    wait_done(d0 + 1, 400, "l1");
    step(5);
    check("l1_one_done", 64'(done_cnt), 64'(d0 + 1));
    chk_drained("l1");

    // Unaligned start: x0=64, 2 beats, single burst of len 1.
    d0 = done_cnt;
    i_x_start = 12'd70; i_x_win = 12'd64;
    exp_line(32'h1100_6040, 2, 1);
    pulse_req();
    wait_done(d0 + 1, 200, "l2");
    chk_drained("l2");

    // Outstanding limit of 2 with slow read data.
    d0 = done_cnt; a0 = ar_cnt; r0 = rl_cyc.size();
    ar_hold = 1'b1; r_delay = 50;
    i_x_start = 12'd0; i_x_win = 12'd3072;
    exp_line(32'h1100_7000, 48, 2);
    pulse_req();
    wait_ar(a0 + 1, 50, "l3_ar");
    step(30);
    check("l3_two_ar", 64'(ar_cnt - a0), 64'(2));
    wait_done(d0 + 1, 600, "l3");
    if (ar_cyc.size() >= a0 + 3 && rl_cyc.size() > r0)
      check("l3_ar3_after_rlast", 64'(ar_cyc[a0 + 2]), 64'(rl_cyc[r0] + 1));
    else begin
      checks++; failures++;
      $display("FAIL l3_ar3_missing actual=%0d required=%0d", ar_cnt - a0, 3);
    end
    chk_drained("l3");

    // Three back-to-back requests while busy: one pended, the rest dropped.
    d0 = done_cnt;
    ar_hold = 1'b0; r_delay = 10;
    i_x_win = 12'd128;
    exp_line(32'h1100_5000, 2, 0);
    exp_line(32'h1100_6000, 2, 1);
    pulse_req();
    wait_busy("l4");
    i_line_req = 1'b1; step(3); i_line_req = 1'b0;
    wait_done(d0 + 2, 300, "l45");
    step(30);
    check("l45_two_done", 64'(done_cnt), 64'(d0 + 2));
    check("l45_ovf", 64'(o_ovf), 64'(1));
    chk_drained("l45");

    // Zero-width window at y=2: done one cycle after start, no AR.
    d0 = done_cnt; a0 = ar_cnt; l0 = lb_cnt;
    i_x_win = 12'd0;
    i_line_req = 1'b1; m = mcyc; step(); i_line_req = 1'b0;
    wait_done(d0 + 1, 10, "lz");
    if (done_cyc.size() > 0) check("lz_done_cycle", 64'(done_cyc[done_cyc.size() - 1]), 64'(m + 3));
    step(5);
    check("lz_no_ar", 64'(ar_cnt - a0), 64'(0));
    check("lz_no_lb", 64'(lb_cnt - l0), 64'(0));

    // y wrapped to 0; then a frame start during the y=1 line.
    d0 = done_cnt;
    i_x_win = 12'd128;
    exp_line(32'h1100_5000, 2, 0);
    pulse_req();
    wait_done(d0 + 1, 200, "lc");
    exp_line(32'h1100_6000, 2, 1);
    pulse_req();
    wait_busy("le");
    i_frame_start = 1'b1; step(); i_frame_start = 1'b0;
    wait_done(d0 + 2, 200, "le");
    exp_line(32'h1100_5000, 2, 0);
    pulse_req();
    wait_done(d0 + 3, 200, "lf");
    chk_drained("lf");

    // Reset with 5 beats outstanding at y=1.
    d0 = done_cnt; a0 = ar_cnt;
    r_delay = 30;
    i_x_win = 12'd320;
    exp_line(32'h1100_6000, 5, 1);
    pulse_req();
    wait_ar(a0 + 1, 50, "lg_ar");
    step(3);
    i_arst = 1'b1;
    #1;
    chk_rst("rst_mid");
    exp_wa.delete(); exp_wd.delete();
    step(2);
    i_arst = 1'b0;
    l0 = lb_cnt;
    step(12);
    check("stale_no_we", 64'(lb_cnt - l0), 64'(0));
    check("lg_no_done", 64'(done_cnt), 64'(d0));
    r_delay = 2;
    i_x_win = 12'd128;
    exp_line(32'h1100_5000, 2, 0);
    pulse_req();
    wait_done(d0 + 1, 200, "lh");
    step(3);
    check("lh_ovf_clear", 64'(o_ovf), 64'(0));
    chk_drained("lh");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
